// File: rtl/apb_cmd_master.sv
// APB master with a command FIFO: each {rw,addr,wdata} command becomes one APB SETUP/ACCESS
// transfer (wait states, PSLVERR, timeout, address decode) and returns one response via valid/ready.
module apb_cmd_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_SLAVES = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                             pclk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH+DATA_WIDTH:0]   cmd_in,
  input  logic                             cmd_vld,
  output logic                             cmd_rdy,
  input  logic                             transfer,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_cnt,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [DATA_WIDTH-1:0]            pwdata,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr,
  output logic                             rsp_vld,
  input  logic                             rsp_rdy,
  output logic                             rsp_rw,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             rsp_err
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CMD_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SEL_W:0] NUM_SEL = NUM_SLAVES[SEL_W:0];

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nxt;

  logic [CMD_W-1:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  full, empty, push, launch;
  logic                  head_rw;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic [SEL_W-1:0]      head_idx, sel_idx;
  logic                  dec_err;
  logic                  sel_ready, sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  timed_out, access_end;

  assign full    = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign empty   = (fifo_cnt == '0);
  assign cmd_rdy = !rst && !full;
  assign push    = cmd_vld && cmd_rdy;

  assign {head_rw, head_addr, head_wdata} = fifo_mem[rd_ptr];
  assign head_idx = head_addr[ADDR_WIDTH-1 -: SEL_W];
  assign dec_err  = ({1'b0, head_idx} >= NUM_SEL);
  // A new transfer only starts once the previous response has been (or is being) taken.
  assign launch   = (state == IDLE) && !empty && transfer && (!rsp_vld || rsp_rdy);

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel_idx == SEL_W'(k)) begin
        sel_ready = pready[k];
        sel_err   = pslverr[k];
        sel_rdata = prdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The counter holds (ACCESS cycle number - 1), so the TIMEOUT-th cycle matches TIMEOUT-1.
  assign timed_out  = (TIMEOUT != 0) && !sel_ready && (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign access_end = (state == ACCESS) && (sel_ready || timed_out);

  always_ff @(posedge pclk) begin
    if (push) fifo_mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (launch) rd_ptr <= rd_ptr + 1'b1;
      case ({push, launch})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch && !dec_err) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (access_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    psel = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      psel[k] = (state != IDLE) && (sel_idx == SEL_W'(k));
    end
    penable = (state == ACCESS);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      sel_idx <= '0;
    end else if (launch) begin
      pwrite  <= head_rw;
      paddr   <= head_addr;
      pwdata  <= head_wdata;
      sel_idx <= head_idx;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst)                   tmo_cnt <= '0;
    else if (state == ACCESS)  tmo_cnt <= tmo_cnt + 1'b1;
    else                       tmo_cnt <= '0;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      rsp_vld  <= 1'b0;
      rsp_rw   <= 1'b0;
      rsp_err  <= 1'b0;
      rsp_data <= '0;
    end else if (access_end) begin
      rsp_vld  <= 1'b1;
      rsp_rw   <= pwrite;
      rsp_err  <= sel_ready ? sel_err : 1'b1;
      rsp_data <= (sel_ready && !pwrite) ? sel_rdata : '0;
    end else if (launch && dec_err) begin
      // Unmapped slave index: answer with an error without touching the bus.
      rsp_vld  <= 1'b1;
      rsp_rw   <= head_rw;
      rsp_err  <= 1'b1;
      rsp_data <= '0;
    end else if (rsp_rdy) begin
      rsp_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: commands carry a planned slave behaviour, from which the
// expected response is derived at issue time; a slave model and a response monitor check the DUT.
module tb_apb_cmd_master;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int NS = 4;
  localparam int FD = 4;
  localparam int TO = 16;
  localparam int SW = 2;

  logic                 pclk = 1'b0;
  logic                 rst;
  logic [AW+DW:0]       cmd_in;
  logic                 cmd_vld, cmd_rdy, transfer;
  logic [$clog2(FD):0]  fifo_cnt;
  logic [NS-1:0]        psel;
  logic                 penable, pwrite;
  logic [AW-1:0]        paddr;
  logic [DW-1:0]        pwdata;
  logic [NS*DW-1:0]     prdata;
  logic [NS-1:0]        pready, pslverr;
  logic                 rsp_vld, rsp_rdy, rsp_rw, rsp_err;
  logic [DW-1:0]        rsp_data;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;   // ACCESS cycles before pready
    logic          err;
    logic [DW-1:0] rdata;
  } plan_t;

  typedef struct {
    logic          rw;
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  plan_t plan_q[$];
  rsp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    tr_mode = 2;   // 0 random, 1 force 0, 2 force 1
  int    rdy_mode = 2;

  apb_cmd_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLAVES(NS), .FIFO_DEPTH(FD), .TIMEOUT(TO)
  ) dut (
    .pclk(pclk), .rst(rst), .cmd_in(cmd_in), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .transfer(transfer), .fifo_cnt(fifo_cnt), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rw(rsp_rw), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic plan_t mk(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                               input int waits, input logic err, input logic [DW-1:0] rd);
    plan_t p;
    p.rw = rw; p.addr = addr; p.wdata = wd; p.waits = waits; p.err = err; p.rdata = rd;
    return p;
  endfunction

  function automatic plan_t rand_plan();
    plan_t p;
    int    r;
    p.rw    = 1'($urandom);
    p.addr  = AW'($urandom);
    p.wdata = $urandom;
    p.rdata = $urandom;
    p.err   = ($urandom_range(5) == 0);
    r = int'($urandom_range(15));
    if (r < 11)       p.waits = r % 4;
    else if (r < 13)  p.waits = TO - 1;
    else if (r == 13) p.waits = TO;
    else              p.waits = TO + 3;
    return p;
  endfunction

  // Expected response straight from the command's rules: timeout wins, writes return no data.
  task automatic issue(input plan_t p);
    rsp_t e;
    int   n = 0;
    while (!cmd_rdy && n < 500) begin
      @(posedge pclk); #1;
      n++;
    end
    check("issue_cmd_rdy", cmd_rdy, 1);
    if (cmd_rdy) begin
      cmd_in  = {p.rw, p.addr, p.wdata};
      cmd_vld = 1'b1;
      plan_q.push_back(p);
      e.rw   = p.rw;
      e.err  = (p.waits >= TO) ? 1'b1 : p.err;
      e.data = (!p.rw && p.waits < TO) ? p.rdata : '0;
      exp_q.push_back(e);
      @(posedge pclk); #1;
      cmd_vld = 1'b0;
    end
  endtask

  task automatic wait_rsp(input string name, output int n);
    int t = 0;
    n = 0;
    while (t < 300) begin
      @(negedge pclk);
      t++;
      if (penable) n++;
      if (rsp_vld) break;
    end
    check({name, "_rsp_seen"}, rsp_vld, 1);
  endtask

  task automatic drain();
    int t = 0;
    while (t < 3000 && !(exp_q.size() == 0 && plan_q.size() == 0 && psel == '0 &&
                         !rsp_vld && fifo_cnt == 0)) begin
      @(posedge pclk); #1;
      t++;
    end
    check("drain_idle", t < 3000, 1);
  endtask

  initial begin
    transfer = 1'b1;
    rsp_rdy  = 1'b1;
    forever begin
      @(posedge pclk); #1;
      case (tr_mode)
        0:       transfer = ($urandom_range(3) != 0);
        1:       transfer = 1'b0;
        default: transfer = 1'b1;
      endcase
      case (rdy_mode)
        0:       rsp_rdy = ($urandom_range(3) != 0);
        1:       rsp_rdy = 1'b0;
        default: rsp_rdy = 1'b1;
      endcase
    end
  end

  // Slave model: follows the plan of the transfer on the bus and checks the request fields.
  initial begin
    plan_t         cur;
    bit            have = 0;
    int            acc = 0;
    int            idx = 0;
    logic [NS-1:0] exp_psel;
    pready = '0; pslverr = '0; prdata = '0;
    forever begin
      @(negedge pclk);
      pready  = NS'($urandom);
      pslverr = NS'($urandom);
      for (int k = 0; k < NS; k++) prdata[k*DW +: DW] = $urandom;
      if (rst) begin
        have = 0;
      end else if (psel == '0) begin
        check("bus_no_early_end", have, 0);
        have = 0;
      end else if (!penable) begin
        check("setup_not_mid_transfer", have, 0);
        check("setup_has_cmd", plan_q.size() != 0, 1);
        if (plan_q.size() != 0) begin
          cur = plan_q.pop_front();
          have = 1; acc = 0;
          idx = int'(cur.addr[AW-1 -: SW]);
          exp_psel = '0; exp_psel[idx] = 1'b1;
          check("setup_fields", {psel, pwrite, paddr, pwdata}, {exp_psel, cur.rw, cur.addr, cur.wdata});
        end
      end else begin
        check("access_after_setup", have, 1);
        if (have) begin
          acc++;
          check("access_fields", {psel, pwrite, paddr, pwdata}, {exp_psel, cur.rw, cur.addr, cur.wdata});
          pready[idx] = (acc == cur.waits + 1);
          if (pready[idx]) begin
            pslverr[idx] = cur.err;
            prdata[idx*DW +: DW] = cur.rdata;
          end
          if (acc == cur.waits + 1 || acc == TO) have = 0;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on each handshake and checks stalls hold the response.
  initial begin
    rsp_t          e;
    bit            pend = 0;
    logic          prw = 1'b0, perr = 1'b0;
    logic [DW-1:0] pdata = '0;
    forever begin
      @(negedge pclk);
      if (rst) begin
        pend = 0;
      end else begin
        if (pend) check("rsp_hold", {rsp_vld, rsp_rw, rsp_err, rsp_data}, {1'b1, prw, perr, pdata});
        if (rsp_vld && rsp_rdy) begin
          check("rsp_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_rw", rsp_rw, e.rw);
            check("rsp_err", rsp_err, e.err);
            check("rsp_data", rsp_data, e.data);
          end
        end
        pend = rsp_vld && !rsp_rdy;
        prw = rsp_rw; perr = rsp_err; pdata = rsp_data;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; cmd_vld = 1'b0; cmd_in = '0;
    repeat (3) @(posedge pclk);
    #1;
    check("reset_bus", {psel, penable, pwrite, paddr, pwdata}, '0);
    check("reset_rsp", {rsp_vld, rsp_rw, rsp_err, rsp_data}, '0);
    check("reset_fifo_cnt", fifo_cnt, 0);
    check("reset_cmd_rdy", cmd_rdy, 0);
    rst = 1'b0;
    @(posedge pclk); #1;
    check("cmd_rdy_after_reset", cmd_rdy, 1);

    // Zero-wait write latency
    issue(mk(1'b1, 12'h004, 32'h11, 0, 1'b0, 32'hCAFE0000));
    @(negedge pclk); check("t1_c1", {psel, penable}, {4'b0000, 1'b0});
    @(negedge pclk); check("t1_c2", {psel, penable}, {4'b0001, 1'b0});
    @(negedge pclk); check("t1_c3", {psel, penable}, {4'b0001, 1'b1});
    @(negedge pclk); check("t1_c4", {rsp_vld, rsp_err, rsp_data}, {1'b1, 1'b0, 32'h0});
    drain();

    // Read with three wait states
    issue(mk(1'b0, 12'h408, 32'h0, 3, 1'b0, 32'hDEADBEEF));
    wait_rsp("t2", n);
    check("t2_access_cycles", n, 4);
    drain();

    // Fill with transfer held low, then release
    tr_mode = 1;
    @(posedge pclk); #1;
    for (int i = 0; i < 4; i++) issue(rand_plan());
    check("t3_full_cmd_rdy", cmd_rdy, 0);
    check("t3_full_cnt", fifo_cnt, 4);
    cmd_vld = 1'b1;
    cmd_in  = {1'($urandom), AW'($urandom), DW'($urandom)};
    repeat (3) begin
      @(negedge pclk);
      check("t3_no_psel", psel, 0);
      check("t3_cnt_held", fifo_cnt, 4);
    end
    @(posedge pclk); #1;
    cmd_vld = 1'b0;
    tr_mode = 2;
    issue(rand_plan());
    drain();

    // Timeout boundary
    issue(mk(1'b0, AW'($urandom), 32'h0, TO + 3, 1'b0, 32'h12345678));
    wait_rsp("t4a", n);
    check("t4a_access_cycles", n, TO);
    drain();
    issue(mk(1'b0, AW'($urandom), 32'h0, TO - 1, 1'b0, 32'h87654321));
    wait_rsp("t4b", n);
    check("t4b_access_cycles", n, TO);
    drain();

    // PSLVERR with response back-pressure
    rdy_mode = 1;
    @(posedge pclk); #1;
    issue(mk(1'b1, AW'($urandom), 32'hA5A5A5A5, 0, 1'b1, 32'h0));
    issue(mk(1'b0, AW'($urandom), 32'h0, 0, 1'b0, 32'h5A5A5A5A));
    wait_rsp("t5", n);
    repeat (10) begin
      @(negedge pclk);
      check("t5_stall", {rsp_vld, rsp_err, psel}, {1'b1, 1'b1, 4'b0000});
    end
    rdy_mode = 2;
    drain();

    // Reset in the middle of an ACCESS phase
    issue(mk(1'b0, AW'($urandom), 32'h0, 10, 1'b0, 32'h1));
    issue(rand_plan());
    issue(rand_plan());
    n = 0;
    while (!penable && n < 50) begin
      @(posedge pclk); #1;
      n++;
    end
    check("t6_in_access", penable, 1);
    @(posedge pclk); #1;
    rst = 1'b1;
    #1;
    plan_q.delete();
    exp_q.delete();
    check("t6_bus_cleared", {psel, penable}, '0);
    check("t6_fifo_cnt", fifo_cnt, 0);
    check("t6_rsp_vld", rsp_vld, 0);
    check("t6_cmd_rdy_in_reset", cmd_rdy, 0);
    repeat (2) @(posedge pclk);
    #1;
    rst = 1'b0;
    repeat (10) begin
      @(negedge pclk);
      check("t6_quiet", {rsp_vld, psel}, '0);
    end
    check("t6_cmd_rdy_after", cmd_rdy, 1);

    // Randomized traffic with random transfer gating and response back-pressure
    tr_mode = 0;
    rdy_mode = 0;
    for (int i = 0; i < 60; i++) begin
      issue(rand_plan());
      repeat ($urandom_range(2)) @(posedge pclk);
      #1;
    end
    tr_mode = 2;
    rdy_mode = 2;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
